// File: rtl/led_indicator_pkg.sv
// Shared types and helpers for the multi-channel LED indicator.
package led_indicator_pkg;

   localparam int unsigned LED_MODE_W = 3;

   typedef enum logic [LED_MODE_W-1:0] {
      MODE_OFF        = 3'd0,
      MODE_ON         = 3'd1,
      MODE_BLINK_SLOW = 3'd2,
      MODE_BLINK_FAST = 3'd3,
      MODE_STRETCH    = 3'd4
   } led_mode_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_stretch.sv
// Single-channel pulse stretcher: holds `active` for STRETCH_MS ticks after a load.
module led_stretch
   import led_indicator_pkg::*;
#(
   parameter int unsigned STRETCH_MS = 50
) (
   input  logic clk250,
   input  logic nrst,
   input  logic tick,
   input  logic load,
   input  logic clr,
   output logic active
);

   localparam int unsigned CNT_W = $clog2(STRETCH_MS + 1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // A load wins over a same-cycle clear so a mode write plus event stays lit.
   always_comb begin
      cnt_nxt = cnt;
      if (load) begin
         cnt_nxt = CNT_W'(STRETCH_MS);
      end else if (clr) begin
         cnt_nxt = '0;
      end else if (tick && (cnt != '0)) begin
         cnt_nxt = cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk250) begin
      if (!nrst) begin
         cnt    <= '0;
         active <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         active <= (cnt_nxt != '0);
      end
   end

endmodule

// File: rtl/led_indicator.sv
// Multi-channel LED driver: per-channel display mode, shared blink phases,
// event pulse stretching and a registered pin drive.
module led_indicator
   import led_indicator_pkg::*;
#(
   parameter int unsigned N_LEDS     = 6,
   parameter int unsigned TICK_DIV   = 250000,
   parameter int unsigned SLOW_MS    = 500,
   parameter int unsigned FAST_MS    = 100,
   parameter int unsigned STRETCH_MS = 50,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                        clk250,
   input  logic                        nrst,
   input  logic                        cfg_we,
   input  logic [$clog2(N_LEDS)-1:0]   cfg_idx,
   input  logic [LED_MODE_W-1:0]       cfg_mode,
   input  logic [N_LEDS-1:0]           evt,
   output logic [N_LEDS-1:0]           led
);

   localparam int unsigned IDX_W   = $clog2(N_LEDS);
   localparam int unsigned PRESC_W = cnt_w(TICK_DIV);
   localparam int unsigned SLOW_W  = cnt_w(SLOW_MS);
   localparam int unsigned FAST_W  = cnt_w(FAST_MS);

   logic [PRESC_W-1:0] presc;
   logic               tick_c;
   logic [SLOW_W-1:0]  slow_cnt;
   logic [FAST_W-1:0]  fast_cnt;
   logic               slow_ph;
   logic               fast_ph;
   logic [N_LEDS-1:0]  stretch_act;
   logic [N_LEDS-1:0]  lit_c;

   assign tick_c = (presc == PRESC_W'(TICK_DIV - 1));

   // Millisecond prescaler.
   always_ff @(posedge clk250) begin
      if (!nrst) begin
         presc <= '0;
      end else if (tick_c) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_W'(1);
      end
   end

   // Shared blink phases, so every channel in the same blink mode is in step.
   always_ff @(posedge clk250) begin
      if (!nrst) begin
         slow_cnt <= '0;
         fast_cnt <= '0;
         slow_ph  <= 1'b0;
         fast_ph  <= 1'b0;
      end else if (tick_c) begin
         if (slow_cnt == SLOW_W'(SLOW_MS - 1)) begin
            slow_cnt <= '0;
            slow_ph  <= ~slow_ph;
         end else begin
            slow_cnt <= slow_cnt + SLOW_W'(1);
         end
         if (fast_cnt == FAST_W'(FAST_MS - 1)) begin
            fast_cnt <= '0;
            fast_ph  <= ~fast_ph;
         end else begin
            fast_cnt <= fast_cnt + FAST_W'(1);
         end
      end
   end

   for (genvar i = 0; i < int'(N_LEDS); i++) begin : g_ch
      logic [LED_MODE_W-1:0] mode_q;
      logic                  wr_hit_c;
      logic                  stretch_mode_c;
      logic                  load_c;

      // Out-of-range indices never match any channel, so such writes drop.
      assign wr_hit_c       = cfg_we && (cfg_idx == IDX_W'(i));
      assign stretch_mode_c = wr_hit_c ? (cfg_mode == MODE_STRETCH)
                                       : (mode_q == MODE_STRETCH);
      assign load_c         = evt[i] && stretch_mode_c;

      always_ff @(posedge clk250) begin
         if (!nrst) begin
            mode_q <= MODE_OFF;
         end else if (wr_hit_c) begin
            mode_q <= cfg_mode;
         end
      end

      led_stretch #(
         .STRETCH_MS (STRETCH_MS)
      ) u_stretch (
         .clk250 (clk250),
         .nrst   (nrst),
         .tick   (tick_c),
         .load   (load_c),
         .clr    (wr_hit_c),
         .active (stretch_act[i])
      );

      // Reserved codes fall through every term and display as OFF.
      assign lit_c[i] = (mode_q == MODE_ON)
                      | ((mode_q == MODE_BLINK_SLOW) & slow_ph)
                      | ((mode_q == MODE_BLINK_FAST) & fast_ph)
                      | stretch_act[i];
   end

   always_ff @(posedge clk250) begin
      if (!nrst) begin
         led <= {N_LEDS{ACTIVE_LOW}};
      end else begin
         led <= lit_c ^ {N_LEDS{ACTIVE_LOW}};
      end
   end

endmodule

// File: tb/tb_led_indicator.sv
// Bench for led_indicator: scenario tasks checked against an arithmetic
// reference model driven by elapsed clock edges since reset release.
module tb_led_indicator;

   localparam int unsigned NL = 6;
   localparam int unsigned TD = 4;
   localparam int unsigned SL = 3;
   localparam int unsigned FA = 1;
   localparam int unsigned ST = 2;

   logic       clk250;
   logic       nrst;
   logic       cfg_we;
   logic [2:0] cfg_idx;
   logic [2:0] cfg_mode;
   logic [5:0] evt;
   logic [5:0] led;

   int total;
   int bad;

   // Reference model state: modes, last stretch load edge, edges since release.
   int         m_mode  [NL];
   bit         m_valid [NL];
   int         m_last  [NL];
   int         m_e;
   logic [5:0] exp_led;

   led_indicator #(
      .N_LEDS     (NL),
      .TICK_DIV   (TD),
      .SLOW_MS    (SL),
      .FAST_MS    (FA),
      .STRETCH_MS (ST),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk250   (clk250),
      .nrst     (nrst),
      .cfg_we   (cfg_we),
      .cfg_idx  (cfg_idx),
      .cfg_mode (cfg_mode),
      .evt      (evt),
      .led      (led)
   );

   initial clk250 = 1'b0;
   always #2 clk250 = ~clk250;

   // Lit state after m_e released edges: ticks land on every TD-th edge.
   function automatic logic [5:0] model_lit();
      logic [5:0] l;
      int ticks;
      ticks = m_e / int'(TD);
      for (int i = 0; i < int'(NL); i++) begin
         l[i] = (m_mode[i] == 1)
             || (m_mode[i] == 2 && ((ticks / int'(SL)) % 2) == 1)
             || (m_mode[i] == 3 && ((ticks / int'(FA)) % 2) == 1)
             || (m_valid[i] && (ticks - m_last[i] / int'(TD)) < int'(ST));
      end
      return l;
   endfunction

   task automatic step(input logic r, input logic we, input logic [2:0] idx,
                       input logic [2:0] md, input logic [5:0] ev);
      nrst     = r;
      cfg_we   = we;
      cfg_idx  = idx;
      cfg_mode = md;
      evt      = ev;
      @(posedge clk250);
      if (!r) begin
         for (int i = 0; i < int'(NL); i++) begin
            m_mode[i]  = 0;
            m_valid[i] = 1'b0;
            m_last[i]  = 0;
         end
         m_e     = 0;
         exp_led = 6'h3F;
      end else begin
         exp_led = ~model_lit();
         m_e++;
         if (we && int'(idx) < int'(NL)) begin
            m_mode[int'(idx)]  = int'(md);
            m_valid[int'(idx)] = 1'b0;
         end
         for (int i = 0; i < int'(NL); i++) begin
            if (ev[i] && m_mode[i] == 4) begin
               m_valid[i] = 1'b1;
               m_last[i]  = m_e;
            end
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b0, 3'd0, 3'd0, 6'd0);
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 3'd0, 3'd0, 6'd0);
      step(1'b0, 1'b0, 3'd0, 3'd0, 6'd0);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 6'($urandom));
         total++;
         if (led !== 6'h3F) begin
            bad++;
            $display("FAIL reset_hold k=%0d led=%b exp=%b", k, led, 6'h3F);
         end
      end
      step(1'b1, 1'b0, 3'd0, 3'd0, 6'd0);
      total++;
      if (led !== 6'h3F) begin
         bad++;
         $display("FAIL reset_release led=%b exp=%b", led, 6'h3F);
      end
   endtask

   task automatic test_static();
      step(1'b1, 1'b1, 3'd2, 3'd1, 6'd0);
      total++;
      if (led[2] !== 1'b1) begin
         bad++;
         $display("FAIL static_on_same_edge led=%b exp_bit2=1", led);
      end
      idle(1);
      total++;
      if (led[2] !== 1'b0 || led !== exp_led) begin
         bad++;
         $display("FAIL static_on led=%b exp=%b", led, exp_led);
      end
      step(1'b1, 1'b1, 3'd2, 3'd0, 6'd0);
      idle(1);
      total++;
      if (led[2] !== 1'b1 || led !== exp_led) begin
         bad++;
         $display("FAIL static_off led=%b exp=%b", led, exp_led);
      end
      step(1'b1, 1'b1, 3'd6, 3'd1, 6'd0);
      step(1'b1, 1'b1, 3'd7, 3'd1, 6'd0);
      for (int k = 0; k < 3; k++) begin
         idle(1);
         total++;
         if (led !== 6'h3F || led !== exp_led) begin
            bad++;
            $display("FAIL static_bad_idx k=%0d led=%b exp=%b", k, led, exp_led);
         end
      end
   endtask

   task automatic test_blink();
      logic prev0, prev1;
      int   first0, first1, last0, last1;
      do_reset();
      step(1'b1, 1'b1, 3'd0, 3'd2, 6'd0);
      step(1'b1, 1'b1, 3'd1, 3'd3, 6'd0);
      prev0 = 1'b1; prev1 = 1'b1;
      first0 = -1; first1 = -1; last0 = -1; last1 = -1;
      while (m_e < 64) begin
         idle(1);
         total++;
         if (led !== exp_led) begin
            bad++;
            $display("FAIL blink_model e=%0d led=%b exp=%b", m_e, led, exp_led);
         end
         if (led[1] !== prev1) begin
            if (last1 >= 0) begin
               total++;
               if (m_e - last1 != int'(TD * FA)) begin
                  bad++;
                  $display("FAIL blink_fast_period e=%0d got=%0d exp=%0d", m_e, m_e - last1, TD * FA);
               end
            end else begin
               first1 = m_e;
            end
            last1 = m_e;
            prev1 = led[1];
         end
         if (led[0] !== prev0) begin
            if (last0 >= 0) begin
               total++;
               if (m_e - last0 != int'(TD * SL)) begin
                  bad++;
                  $display("FAIL blink_slow_period e=%0d got=%0d exp=%0d", m_e, m_e - last0, TD * SL);
               end
            end else begin
               first0 = m_e;
            end
            last0 = m_e;
            prev0 = led[0];
         end
      end
      total++;
      if (first1 != int'(TD * FA) + 1) begin
         bad++;
         $display("FAIL blink_fast_first got=%0d exp=%0d", first1, TD * FA + 1);
      end
      total++;
      if (first0 != int'(TD * SL) + 1) begin
         bad++;
         $display("FAIL blink_slow_first got=%0d exp=%0d", first0, TD * SL + 1);
      end
   endtask

   // Count cycles led[ch] stays low after the current edge, bounded.
   task automatic measure_low(input int ch, input string nm, output int cnt);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         idle(1);
         total++;
         if (led !== exp_led) begin
            bad++;
            $display("FAIL %s_model e=%0d led=%b exp=%b", nm, m_e, led, exp_led);
         end
         if (led[ch] === 1'b0) cnt++;
         else break;
      end
   endtask

   task automatic test_stretch();
      int m0, dur, cnt;
      logic [1:0] targets [2];
      targets[0] = 2'd3;
      targets[1] = 2'd2;
      do_reset();
      step(1'b1, 1'b1, 3'd4, 3'd4, 6'd0);
      for (int t = 0; t < 2; t++) begin
         idle(12);
         for (int k = 0; k < int'(TD) && (m_e % int'(TD)) != int'(targets[t]); k++) idle(1);
         m0  = m_e + 1;
         dur = (m0 / int'(TD) + int'(ST)) * int'(TD) - m0;
         step(1'b1, 1'b0, 3'd0, 3'd0, 6'b010000);
         measure_low(4, "stretch", cnt);
         total++;
         if (cnt != dur || cnt < int'((ST - 1) * TD + 1) || cnt > int'(ST * TD)) begin
            bad++;
            $display("FAIL stretch_len presc=%0d got=%0d exp=%0d", targets[t], cnt, dur);
         end
      end
   endtask

   task automatic test_retrigger();
      int m1, dur, cnt;
      idle(12);
      step(1'b1, 1'b0, 3'd0, 3'd0, 6'b010000);
      idle(3);
      m1  = m_e + 1;
      dur = (m1 / int'(TD) + int'(ST)) * int'(TD) - m1;
      step(1'b1, 1'b0, 3'd0, 3'd0, 6'b010000);
      measure_low(4, "retrig", cnt);
      total++;
      if (cnt != dur) begin
         bad++;
         $display("FAIL retrig_len got=%0d exp=%0d", cnt, dur);
      end
      step(1'b1, 1'b1, 3'd5, 3'd4, 6'b100000);
      idle(1);
      total++;
      if (led[5] !== 1'b0 || led !== exp_led) begin
         bad++;
         $display("FAIL simul_write_evt led=%b exp=%b", led, exp_led);
      end
      step(1'b1, 1'b0, 3'd0, 3'd0, 6'b001000);
      for (int k = 0; k < 3; k++) begin
         idle(1);
         total++;
         if (led[3] !== 1'b1 || led !== exp_led) begin
            bad++;
            $display("FAIL evt_mode_off k=%0d led=%b exp=%b", k, led, exp_led);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(1'b1, 1'b1, 3'd0, 3'd4, 6'd0);
      step(1'b1, 1'b1, 3'd1, 3'd3, 6'd0);
      step(1'b1, 1'b1, 3'd2, 3'd2, 6'd0);
      step(1'b1, 1'b1, 3'd4, 3'd4, 6'd0);
      idle(14);
      step(1'b1, 1'b0, 3'd0, 3'd0, 6'b010001);
      step(1'b0, 1'b0, 3'd0, 3'd0, 6'd0);
      total++;
      if (led !== 6'h3F) begin
         bad++;
         $display("FAIL reset_mid led=%b exp=%b", led, 6'h3F);
      end
      for (int k = 0; k < 12; k++) begin
         idle(1);
         total++;
         if (led[0] !== 1'b1 || led !== exp_led) begin
            bad++;
            $display("FAIL reset_mid_after k=%0d led=%b exp=%b", k, led, exp_led);
         end
      end
   endtask

   task automatic test_random();
      logic r;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         r = ($urandom_range(0, 199) != 0);
         step(r, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 6'($urandom & $urandom));
         total++;
         if (led !== exp_led) begin
            bad++;
            $display("FAIL random k=%0d e=%0d led=%b exp=%b", k, m_e, led, exp_led);
         end
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      m_e     = 0;
      exp_led = 6'h3F;
      for (int i = 0; i < int'(NL); i++) begin
         m_mode[i]  = 0;
         m_valid[i] = 1'b0;
         m_last[i]  = 0;
      end
      nrst     = 1'b0;
      cfg_we   = 1'b0;
      cfg_idx  = 3'd0;
      cfg_mode = 3'd0;
      evt      = 6'd0;
      test_reset();
      test_static();
      test_blink();
      test_stretch();
      test_retrigger();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
